// File: rtl/arc_pkg.sv
// rtl/arc_pkg.sv - shared ARC datapath constants, register indices and PSR flag positions
package arc_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 38;

  localparam int R0     = 0;
  localparam int PC_IDX = 32;
  localparam int TEMP0  = 33;
  localparam int TEMP1  = 34;
  localparam int TEMP2  = 35;
  localparam int TEMP3  = 36;
  localparam int IR_IDX = 37;

  localparam logic [DATA_W-1:0] PC_RESET = '0;

  localparam int PSR_W = 4;
  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  function automatic logic psr_n(input logic [PSR_W-1:0] psr);
    return psr[PSR_N];
  endfunction

  function automatic logic psr_z(input logic [PSR_W-1:0] psr);
    return psr[PSR_Z];
  endfunction

  function automatic logic psr_v(input logic [PSR_W-1:0] psr);
    return psr[PSR_V];
  endfunction

  function automatic logic psr_c(input logic [PSR_W-1:0] psr);
    return psr[PSR_C];
  endfunction

endpackage

// File: rtl/arc_psr_reg.sv
// rtl/arc_psr_reg.sv - 4-bit {n,z,v,c} processor status register with load enable
module arc_psr_reg
  import arc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic [PSR_W-1:0] flags_i,
  output logic [PSR_W-1:0] flags_o
);

  logic [PSR_W-1:0] flags_q;
  logic [PSR_W-1:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (ld_i) flags_d = flags_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flags_q <= '0;
    else         flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/arc_regfile.sv
// rtl/arc_regfile.sv - ARC register file (r0-r31, %pc, temp0-3, %ir) with PSR and two async read ports
module arc_regfile #(
  parameter int                DATA_W   = arc_pkg::DATA_W,
  parameter int                ADDR_W   = arc_pkg::ADDR_W,
  parameter int                NUM_REGS = arc_pkg::NUM_REGS,
  parameter int                PC_IDX   = arc_pkg::PC_IDX,
  parameter int                IR_IDX   = arc_pkg::IR_IDX,
  parameter logic [DATA_W-1:0] PC_RESET = arc_pkg::PC_RESET
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          a_addr,
  input  logic [ADDR_W-1:0]          b_addr,
  input  logic [ADDR_W-1:0]          c_addr,
  input  logic                       c_we,
  input  logic [DATA_W-1:0]          busC,
  input  logic [arc_pkg::PSR_W-1:0]  psr_in,
  input  logic                       psr_we,
  output logic [DATA_W-1:0]          busA,
  output logic [DATA_W-1:0]          busB,
  output logic [DATA_W-1:0]          pc_out,
  output logic [DATA_W-1:0]          ir_out,
  output logic [arc_pkg::PSR_W-1:0]  psr_out
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_en;
  logic              a_valid;
  logic              b_valid;

  // r0 is never written, so it keeps its reset value of zero forever
  assign wr_en   = c_we && (c_addr != '0) && (c_addr < ADDR_W'(NUM_REGS));
  assign a_valid = a_addr < ADDR_W'(NUM_REGS);
  assign b_valid = b_addr < ADDR_W'(NUM_REGS);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[c_addr] = busC;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == PC_IDX) ? PC_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the flops: a same-cycle write is not bypassed
  assign busA   = a_valid ? regs_q[a_addr] : '0;
  assign busB   = b_valid ? regs_q[b_addr] : '0;
  assign pc_out = regs_q[PC_IDX];
  assign ir_out = regs_q[IR_IDX];

  arc_psr_reg u_psr (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .ld_i    (psr_we),
    .flags_i (psr_in),
    .flags_o (psr_out)
  );

endmodule

// File: tb/tb_arc_regfile.sv
// tb/tb_arc_regfile.sv - scoreboard testbench for arc_regfile
module tb_arc_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  a_addr, b_addr, c_addr;
  logic        c_we;
  logic [31:0] busC;
  logic [3:0]  psr_in;
  logic        psr_we;
  logic [31:0] busA, busB, pc_out, ir_out;
  logic [3:0]  psr_out;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [3:0]  psr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  arc_regfile dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .c_addr  (c_addr),
    .c_we    (c_we),
    .busC    (busC),
    .psr_in  (psr_in),
    .psr_we  (psr_we),
    .busA    (busA),
    .busB    (busB),
    .pc_out  (pc_out),
    .ir_out  (ir_out),
    .psr_out (psr_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every queued expectation is compared
  // on the falling edge following the cycle in which it was pushed.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.nm, "/busA"}, busA, e.a);
        chk({e.nm, "/busB"}, busB, e.b);
        chk({e.nm, "/pc"},   pc_out, e.pc);
        chk({e.nm, "/ir"},   ir_out, e.ir);
        chk({e.nm, "/psr"},  {28'd0, psr_out}, {28'd0, e.psr});
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] ir, input logic [3:0] psr);
    exp_t e;
    e.nm = nm; e.a = a; e.b = b; e.pc = pc; e.ir = ir; e.psr = psr;
    sb_q.push_back(e);
  endtask

  // One cycle: drive just after the rising edge, expectation is the pre-edge view.
  task automatic step(input string nm,
                      input logic [5:0] aa, input logic [5:0] ba,
                      input logic [5:0] ca, input logic [31:0] cd, input logic cw,
                      input logic [3:0] pi, input logic pw,
                      input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] epc, input logic [31:0] eir, input logic [3:0] epsr);
    @(posedge clk);
    #1;
    a_addr = aa; b_addr = ba; c_addr = ca; busC = cd; c_we = cw;
    psr_in = pi; psr_we = pw;
    push(nm, ea, eb, epc, eir, epsr);
  endtask

  logic [31:0] snap [38];

  initial begin : stim
    reset_n = 1'b0;
    a_addr = 6'd32; b_addr = 6'd37; c_addr = '0; busC = '0; c_we = 1'b0;
    psr_in = '0; psr_we = 1'b0;
    #2;
    push("reset0", 32'h0, 32'h0, 32'h0, 32'h0, 4'h0);
    #10;
    reset_n = 1'b1;

    //    name        a   b   c   busC          we    pin    pwe   expA          expB          pc            ir            psr
    step("wr_r5",     5,  5,  5,  32'hDEADBEEF, 1'b1, 4'h0,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        4'h0);
    step("rd_r5",     5,  5,  0,  32'h0,        1'b0, 4'h0,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        4'h0);
    step("wr_r0",     0,  5,  0,  32'hFFFFFFFF, 1'b1, 4'h0,  1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        4'h0);
    step("rd_r0",     0,  0,  0,  32'h0,        1'b0, 4'h0,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        4'h0);
    step("wr_pc",     32, 5,  32, 32'h100,      1'b1, 4'h0,  1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        4'h0);
    step("coll_pre",  32, 32, 32, 32'h104,      1'b1, 4'h0,  1'b0, 32'h100,      32'h100,      32'h100,      32'h0,        4'h0);
    step("coll_post", 32, 32, 0,  32'h0,        1'b0, 4'h0,  1'b0, 32'h104,      32'h104,      32'h104,      32'h0,        4'h0);
    step("psr_ld",    0,  0,  0,  32'h0,        1'b0, 4'hA,  1'b1, 32'h0,        32'h0,        32'h104,      32'h0,        4'h0);
    step("psr_hold",  0,  0,  0,  32'h0,        1'b0, 4'h5,  1'b0, 32'h0,        32'h0,        32'h104,      32'h0,        4'hA);
    step("both_we",   6,  6,  6,  32'h6,        1'b1, 4'h5,  1'b1, 32'h0,        32'h0,        32'h104,      32'h0,        4'hA);
    step("both_post", 6,  6,  0,  32'h0,        1'b0, 4'h0,  1'b0, 32'h6,        32'h6,        32'h104,      32'h0,        4'h5);
    step("oor_wr",    40, 63, 40, 32'h1234,     1'b1, 4'h0,  1'b0, 32'h0,        32'h0,        32'h104,      32'h0,        4'h5);

    for (int i = 0; i < 38; i++) snap[i] = 32'h0;
    snap[5]  = 32'hDEADBEEF;
    snap[6]  = 32'h6;
    snap[32] = 32'h104;
    for (int i = 0; i < 38; i++) begin
      step($sformatf("sweep%0d", i), 6'(i), 6'(i), 0, 32'h0, 1'b0, 4'h0, 1'b0,
           snap[i], snap[i], 32'h104, 32'h0, 4'h5);
    end
    step("oor_rd",    40, 63, 0,  32'h0,        1'b0, 4'h0,  1'b0, 32'h0,        32'h0,        32'h104,      32'h0,        4'h5);

    step("wr_t3",     36, 37, 36, 32'hAAAA5555, 1'b1, 4'h0,  1'b0, 32'h0,        32'h0,        32'h104,      32'h0,        4'h5);
    step("wr_ir",     36, 37, 37, 32'h82006004, 1'b1, 4'h0,  1'b0, 32'hAAAA5555, 32'h0,        32'h104,      32'h0,        4'h5);
    step("rd_ir",     37, 36, 0,  32'h0,        1'b0, 4'h0,  1'b0, 32'h82006004, 32'hAAAA5555, 32'h104,      32'h82006004, 4'h5);

    // Asynchronous reset with a write pending: state clears before any rising edge
    @(posedge clk);
    #1;
    a_addr = 6'd36; b_addr = 6'd5; c_addr = 6'd7; busC = 32'h77; c_we = 1'b1;
    #1;
    reset_n = 1'b0;
    push("rst_async", 32'h0, 32'h0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    a_addr = 6'd7;
    push("rst_hold", 32'h0, 32'h0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    #1;
    c_we = 1'b0;
    reset_n = 1'b1;
    step("post_rst",  7,  32, 0,  32'h0,        1'b0, 4'h0,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        4'h0);

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arc_regfile.md
Name: arc_regfile

Overview:
- Register file and processor status register (PSR) for the ARC datapath.
- Drives the ALU's 32-bit A and B source buses from two asynchronous read ports.
- Captures the ALU C-bus result, and optionally the 4-bit {n,z,v,c} flag vector, on the clock edge.
- Holds the 38 architectural and microarchitectural registers: r0-r31, %pc (r32), temp0-temp3 (r33-r36), %ir (r37). It also exports %pc, %ir and the PSR flags to the control unit.

Parameters:
- DATA_W, 32, data width of every register and bus.
- ADDR_W, 6, width of the register address fields.
- NUM_REGS, 38, number of implemented registers (indices 0..NUM_REGS-1).
- PC_IDX, 32, index of %pc.
- IR_IDX, 37, index of %ir.
- PC_RESET, 32'h0000_0000, value loaded into %pc on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_addr  in  ADDR_W  busA source register index.
- b_addr  in  ADDR_W  busB source register index.
- c_addr  in  ADDR_W  busC destination register index.
- c_we  in  1  write enable for busC into c_addr.
- busC  in  DATA_W  ALU result to be written.
- psr_in  in  4  ALU flags {n,z,v,c}.
- psr_we  in  1  load psr_in into PSR (asserted by control for the ANDCC/ORCC/NORCC/ADDCC functions).
- busA  out  DATA_W  contents of register a_addr.
- busB  out  DATA_W  contents of register b_addr.
- pc_out  out  DATA_W  current %pc.
- ir_out  out  DATA_W  current %ir.
- psr_out  out  4  current PSR {n,z,v,c}.

Behaviour:
- Reset: asynchronous on reset_n low, held while low.
  - All registers clear to 0, except %pc, which loads PC_RESET.
  - PSR clears to 4'b0000.
  - busA, busB, pc_out, ir_out and psr_out therefore show these values combinationally during reset.
- Reads: purely combinational, zero-cycle latency.
  - busA = reg[a_addr]; busB = reg[b_addr].
  - a_addr = b_addr is legal; both buses carry the same value.
- r0: always reads 0; writes to index 0 are discarded.
- Unimplemented indices (NUM_REGS..2^ADDR_W-1): read as 0; writes discarded; no other state changes.
- Write: on the rising clk edge with c_we = 1 and c_addr a valid nonzero index, reg[c_addr] <= busC. With c_we = 0, no register changes.
- Read/write collision: no bypass. A read of c_addr in the same cycle as a write returns the old value until after the edge. The microsequencer relies on this for read-modify-write, e.g. %pc <- %pc + 4 in one microinstruction.
- PSR: on the rising edge with psr_we = 1, PSR <= psr_in. psr_we and c_we are independent, so any combination, including both, in one cycle is legal.
- pc_out and ir_out: always reflect reg[PC_IDX] and reg[IR_IDX]. A write to either is visible on the next cycle.
- Reset mid-operation: reset overrides any write in the same cycle. No partial update.
- No X propagation: every output is defined for every address value.

Decomposition:
- Shared package arc_pkg holds:
  - DATA_W, ADDR_W and NUM_REGS;
  - named register indices R0, PC_IDX, TEMP0..TEMP3, IR_IDX;
  - PSR bit positions PSR_N = 3, PSR_Z = 2, PSR_V = 1, PSR_C = 0.
- The ALU and the control unit import the same constants.
- Natural sub-module: arc_psr_reg, a 4-bit flag register with load enable, async active-low reset and bit accessors. Instantiated once here; the branch-condition logic reads it.

Test Plan:
- Reset: drive reset_n = 0 mid-simulation after arbitrary writes -> all reads 0, pc_out = PC_RESET, psr_out = 0000, immediately and asynchronously, before any clk edge.
- Basic write/read: c_addr = 5, busC = 32'hDEAD_BEEF, c_we = 1, one edge; then a_addr = b_addr = 5 -> busA = busB = 32'hDEAD_BEEF. Write r0 with 32'hFFFF_FFFF -> busA(0) stays 0.
- Collision: %pc = 32'h0000_0100; a_addr = 32, c_addr = 32, busC = 32'h0000_0104, c_we = 1 -> busA = 32'h100 before the edge, 32'h104 after; pc_out follows.
- PSR: psr_in = 4'b1010, psr_we = 1 -> psr_out = 1010 after the edge. Next cycle psr_in = 4'b0101, psr_we = 0 -> psr_out stays 1010. Same-cycle c_we + psr_we updates both.
- Out-of-range: c_addr = 40, busC = 32'h1234, c_we = 1 -> all 38 registers unchanged; a_addr = 40 reads 0.
- Temps and IR: write temp3 (36) = 32'hAAAA_5555 and IR (37) = 32'h8200_6004 on consecutive edges -> ir_out = 32'h8200_6004; busB(36) = 32'hAAAA_5555.
